// File: rtl/exc_ctrl.sv
// exc_ctrl: exception/interrupt sequencer between the MEM stage and CP0.
// Picks the highest-priority event from int_pend and exc_vec_i in IDLE, shows it
// to CP0 for one cycle, stalls the pipeline while CP0 updates, captures the CP0
// vector and hands it to IF over a valid/ready redirect handshake.
// Optional macro EXC_COUNT_EN adds exc_count_o, a saturating count of issued
// non-eret events.
// Ports:
//   clk, rst_n            clock, synchronous active-high reset
//   int_i / int_sync_o    raw external interrupts / synchronised copy to CP0
//   status_i, cause_i     CP0 status and cause registers
//   mem_valid_i, mem_pc_i, mem_in_delay_i, exc_vec_i   MEM-stage event inputs
//   cp0_excaddr_i         CP0 exception vector / EPC
//   exccode_o, pc_o, in_delay_o                        event presented to CP0
//   stall_o               pipeline freeze
//   redirect_valid_o, redirect_pc_o, redirect_ready_i  fetch redirect handshake
//   exc_count_o           (EXC_COUNT_EN only) issued exception count
module exc_ctrl #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  int_i,
  output logic [5:0]  int_sync_o,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_delay_i,
  input  logic [7:0]  exc_vec_i,
  input  logic [31:0] cp0_excaddr_i,
  output logic [4:0]  exccode_o,
  output logic [31:0] pc_o,
  output logic        in_delay_o,
  output logic        stall_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
`ifdef EXC_COUNT_EN
  output logic [15:0] exc_count_o,
`endif
  input  logic        redirect_ready_i
);

  localparam int unsigned CODE_W = 5;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned INT_W  = 6;

  localparam logic [CODE_W-1:0] CODE_NONE = 5'h10;
  localparam logic [CODE_W-1:0] CODE_INT  = 5'h00;
  localparam logic [CODE_W-1:0] CODE_ADEL = 5'h04;
  localparam logic [CODE_W-1:0] CODE_ADES = 5'h05;
  localparam logic [CODE_W-1:0] CODE_SYS  = 5'h08;
  localparam logic [CODE_W-1:0] CODE_BP   = 5'h09;
  localparam logic [CODE_W-1:0] CODE_RI   = 5'h0A;
  localparam logic [CODE_W-1:0] CODE_OV   = 5'h0C;
  localparam logic [CODE_W-1:0] CODE_ERET = 5'h11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_DRAIN,
    S_WAIT_ACK
  } state_e;

  state_e              state, state_nxt;
  logic [CNT_W-1:0]    drain_cnt;
  logic [INT_W-1:0]    sync_q [SYNC_STAGES];
  logic                int_pend_c;
  logic                evt_c;
  logic [CODE_W-1:0]   evt_code_c;
  logic [CODE_W-1:0]   exccode_nxt;
  logic                stall_nxt;
  logic                rvalid_nxt;
  logic                take_evt;

  // Register fields this block does not look at.
  logic unused_bits;
  assign unused_bits = ^{status_i[31:16], status_i[9:2], cause_i[31:16], cause_i[9:0]};

  // Interrupt synchroniser chain.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= int_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end
  assign int_sync_o = sync_q[SYNC_STAGES-1];

  // Interrupt pending: IE set, EXL clear, some unmasked cause bit.
  assign int_pend_c = status_i[0] & ~status_i[1] & (|(cause_i[15:10] & status_i[15:10]));

  // Fixed-priority encoder over interrupt and MEM exception flags.
  always_comb begin
    evt_c      = 1'b1;
    evt_code_c = CODE_NONE;
    if (int_pend_c)        evt_code_c = CODE_INT;
    else if (exc_vec_i[0]) evt_code_c = CODE_ADEL;
    else if (exc_vec_i[1]) evt_code_c = CODE_RI;
    else if (exc_vec_i[2]) evt_code_c = CODE_OV;
    else if (exc_vec_i[3]) evt_code_c = CODE_SYS;
    else if (exc_vec_i[4]) evt_code_c = CODE_BP;
    else if (exc_vec_i[5]) evt_code_c = CODE_ADEL;
    else if (exc_vec_i[6]) evt_code_c = CODE_ADES;
    else if (exc_vec_i[7]) evt_code_c = CODE_ERET;
    else                   evt_c      = 1'b0;
  end

  assign take_evt = (state == S_IDLE) & mem_valid_i & evt_c;

  // State register and datapath latches.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state            <= S_IDLE;
      drain_cnt        <= '0;
      exccode_o        <= CODE_NONE;
      pc_o             <= '0;
      in_delay_o       <= 1'b0;
      stall_o          <= 1'b0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
    end else begin
      state            <= state_nxt;
      exccode_o        <= exccode_nxt;
      stall_o          <= stall_nxt;
      redirect_valid_o <= rvalid_nxt;
      if (take_evt) begin
        pc_o       <= mem_pc_i;
        in_delay_o <= mem_in_delay_i;
      end
      // CP0 updated its vector on the ISSUE edge, so it is stable in CAPTURE.
      if (state == S_CAPTURE) begin
        redirect_pc_o <= cp0_excaddr_i;
        drain_cnt     <= CNT_W'(DRAIN_CYCLES - 1);
      end else if (state == S_DRAIN) begin
        drain_cnt <= drain_cnt - CNT_W'(1);
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (take_evt) state_nxt = S_ISSUE;
      S_ISSUE:    state_nxt = S_CAPTURE;
      S_CAPTURE:  state_nxt = S_DRAIN;
      S_DRAIN:    if (drain_cnt == '0) state_nxt = S_WAIT_ACK;
      S_WAIT_ACK: if (redirect_valid_o & redirect_ready_i) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Output logic: values for the registered outputs, keyed on the coming state.
  always_comb begin
    exccode_nxt = CODE_NONE;
    stall_nxt   = 1'b0;
    rvalid_nxt  = 1'b0;
    if (take_evt)                exccode_nxt = evt_code_c;
    if (state_nxt != S_IDLE)     stall_nxt   = 1'b1;
    if (state_nxt == S_WAIT_ACK) rvalid_nxt  = 1'b1;
  end

`ifdef EXC_COUNT_EN
  // Saturating count of issued events other than eret.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      exc_count_o <= '0;
    end else if ((state == S_ISSUE) && (exccode_o != CODE_ERET) && (exc_count_o != 16'hFFFF)) begin
      exc_count_o <= exc_count_o + 16'd1;
    end
  end
`endif

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception/interrupt sequencer placed between the MEM stage and the CP0 register block.
- Synchronises external interrupts and prioritises MEM-stage exception flags into a single exccode per event.
- Presents each event to CP0 for exactly one cycle, stalls the pipeline while CP0 updates, and hands the CP0 vector to IF over a valid/ready redirect handshake.

Parameters:
- SYNC_STAGES, 2, flops in the int_i synchroniser; legal range 2..4.
- DRAIN_CYCLES, 2, cycles spent in DRAIN; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous reset, active-high (1 = reset)
- int_i  input  6  asynchronous external interrupt lines
- int_sync_o  output  6  synchronised interrupts, to CP0 int_i
- status_i  input  32  CP0 status_o
- cause_i  input  32  CP0 cause_o
- mem_valid_i  input  1  MEM stage holds a real instruction
- mem_pc_i  input  32  MEM-stage PC
- mem_in_delay_i  input  1  MEM instruction is in a delay slot
- exc_vec_i  input  8  bit0 fetch AdEL, bit1 RI, bit2 Ov, bit3 Sys, bit4 Bp, bit5 data AdEL, bit6 data AdES, bit7 eret
- cp0_excaddr_i  input  32  CP0 cp0_excaddr
- exccode_o  output  5  to CP0 exccode_i
- pc_o  output  32  to CP0 pc_i
- in_delay_o  output  1  to CP0 in_delay_i
- stall_o  output  1  freeze pipeline
- redirect_valid_o  output  1  redirect PC is valid
- redirect_pc_o  output  32  fetch target
- redirect_ready_i  input  1  IF accepts the redirect

Behaviour:
- Reset (rst_n=1 at a clock edge):
  - State goes to IDLE; synchroniser flops clear.
  - exccode_o=5'h10; pc_o=0; in_delay_o=0; stall_o=0; redirect_valid_o=0; redirect_pc_o=0; int_sync_o=0.
  - Reset asserted in any state aborts the sequence in progress with no redirect.
- int_sync_o: int_i passed through a SYNC_STAGES-deep flop chain, so latency is SYNC_STAGES cycles.
- Interrupt-pending condition (combinational):
  - int_pend = status_i[0] & ~status_i[1] & |(cause_i[15:10] & status_i[15:10]).
- Priority, evaluated only in IDLE with mem_valid_i=1 (highest first):
  - int_pend -> 0x00
  - bit0 -> 0x04
  - bit1 -> 0x0A
  - bit2 -> 0x0C
  - bit3 -> 0x08
  - bit4 -> 0x09
  - bit5 -> 0x04
  - bit6 -> 0x05
  - bit7 -> 0x11 (eret)
  - If none is set, no event.
- IDLE:
  - exccode_o=0x10 and stall_o=0.
  - On an event: latch code, mem_pc_i and mem_in_delay_i, then go to ISSUE.
- ISSUE (exactly 1 cycle):
  - exccode_o=latched code; pc_o and in_delay_o = latched values; stall_o=1.
  - Go to CAPTURE.
- CAPTURE (1 cycle):
  - exccode_o=0x10; stall_o=1.
  - redirect_pc_o <= cp0_excaddr_i. CP0 registers its vector on the ISSUE edge, so the value is valid here.
  - Go to DRAIN.
- DRAIN:
  - stall_o=1; a 4-bit counter runs DRAIN_CYCLES cycles.
  - Then go to WAIT_ACK.
- WAIT_ACK:
  - stall_o=1; redirect_valid_o=1.
  - redirect_pc_o is held stable until the handshake.
  - On redirect_valid_o & redirect_ready_i: go to IDLE; redirect_valid_o=0 and stall_o=0 next cycle.
- Total latency, event to earliest redirect handshake: 3+DRAIN_CYCLES cycles.
- Events and interrupts arriving outside IDLE are ignored, not queued. A real interrupt stays visible through cause_i/status_i and is taken on a later IDLE cycle.
- An eret sequence is identical to an exception: redirect_pc_o is whatever CP0 supplied (EPC, or wdata on a same-cycle EPC write).
- exc_vec_i with mem_valid_i=0 is ignored, including a pending interrupt.
- The design never issues two events back to back: at least DRAIN_CYCLES+3 cycles separate consecutive ISSUE states.

Optional Feature:
- Macro: EXC_COUNT_EN.
- Defined:
  - Adds output exc_count_o[15:0].
  - Increments by 1 in each ISSUE cycle whose code is not 0x11.
  - Saturates at 0xFFFF; cleared on reset.
- Undefined: the port and counter are absent; all other behaviour is unchanged.

Test Plan:
- Ov only: exc_vec_i=0x04, mem_valid_i=1, pc=0x80 -> one ISSUE cycle with exccode_o=0x0C, pc_o=0x80; stall_o high; redirect_pc_o=0x100; redirect_valid_o rises 3+DRAIN_CYCLES cycles after the event.
- Priority: exc_vec_i=0x1E (RI, Ov, Sys, Bp) -> exccode_o=0x0A; with int_pend also true -> 0x00.
- Delay slot: mem_in_delay_i=1, Sys, pc=0x104 -> in_delay_o=1 and pc_o=0x104 during ISSUE.
- Interrupt: status_i=0x00000401, int_i[0]=1 -> int_sync_o[0]=1 after 2 cycles; with cause_i[10]=1 and mem_valid_i=1 -> exccode_o=0x00. Same with status_i[1]=1 -> no event.
- Backpressure and reset:
  - redirect_ready_i held low 10 cycles -> redirect_valid_o and redirect_pc_o stable, stall_o=1, new exc_vec_i ignored.
  - rst_n=1 during DRAIN -> IDLE next cycle; all outputs at reset values; no redirect issued.
- EXC_COUNT_EN: 3 exceptions plus 1 eret -> exc_count_o=3.
